data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Arbitrates a CPU port and a debug port onto one data-memory interface.
//   Each transaction takes three cycles: grant (IDLE), memory access
//   (ACCESS) and completion (RESP). The two ports are served round-robin,
//   and i_dbg_lock holds off new CPU grants.
//
// Ports
//   i_clk, i_rst_n              clock, asynchronous active-low reset
//   i_cpu_* / i_dbg_*           req, we, addr, wdata, size (00 word, 01 half,
//                               11 byte, 10 illegal) of each requester
//   i_dbg_lock                  blocks new CPU grants while high
//   o_cpu_gnt / o_dbg_gnt       one-cycle pulse: request accepted
//   o_cpu_ack / o_dbg_ack       one-cycle pulse: transaction complete
//   o_rdata, o_err              read data / fault flag, valid with ack
//   o_mem_*                     memory-side read and write channels
//   i_mem_r_data                combinational memory read data
module data_mem_arbiter #(
  parameter int NB_DATA_BUS = 32,
  parameter int N_ADDRESS   = 64,
  parameter int NB_ADDRESS  = $clog2(N_ADDRESS)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_cpu_req,
  input  logic                   i_cpu_we,
  input  logic [NB_ADDRESS-1:0]  i_cpu_addr,
  input  logic [NB_DATA_BUS-1:0] i_cpu_wdata,
  input  logic [1:0]             i_cpu_size,
  input  logic                   i_dbg_req,
  input  logic                   i_dbg_we,
  input  logic [NB_ADDRESS-1:0]  i_dbg_addr,
  input  logic [NB_DATA_BUS-1:0] i_dbg_wdata,
  input  logic [1:0]             i_dbg_size,
  input  logic                   i_dbg_lock,
  output logic                   o_cpu_gnt,
  output logic                   o_dbg_gnt,
  output logic                   o_cpu_ack,
  output logic                   o_dbg_ack,
  output logic [NB_DATA_BUS-1:0] o_rdata,
  output logic                   o_err,
  output logic [NB_ADDRESS-1:0]  o_mem_r_addr,
  output logic [NB_ADDRESS-1:0]  o_mem_w_addr,
  output logic                   o_mem_r_en,
  output logic                   o_mem_w_en,
  output logic [1:0]             o_mem_r_addressing,
  output logic [1:0]             o_mem_w_addressing,
  output logic [NB_DATA_BUS-1:0] o_mem_w_data,
  input  logic [NB_DATA_BUS-1:0] i_mem_r_data
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_RESP = 2'd2} state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic                    r_last_dbg;   // 1: debug port was granted last
  logic                    r_we;
  logic [NB_ADDRESS-1:0]   r_addr;
  logic [NB_DATA_BUS-1:0]  r_wdata;
  logic [1:0]              r_size;
  logic                    r_port_dbg;
  logic                    r_fault;
  logic [NB_DATA_BUS-1:0]  r_rdata;

  logic                    w_cpu_elig;
  logic                    w_dbg_elig;
  logic                    w_grant_cpu;
  logic                    w_grant_dbg;
  logic                    w_sel_we;
  logic [NB_ADDRESS-1:0]   w_sel_addr;
  logic [NB_DATA_BUS-1:0]  w_sel_wdata;
  logic [1:0]              w_sel_size;
  logic                    w_sel_fault;
  logic                    w_do_write;
  logic                    w_do_read;

  // Grants are combinational in IDLE. Gating with i_rst_n keeps every output
  // low while reset is held, even though the request inputs may be active.
  assign w_cpu_elig  = i_cpu_req & ~i_dbg_lock;
  assign w_dbg_elig  = i_dbg_req;
  assign w_grant_cpu = (r_state == S_IDLE) & i_rst_n & w_cpu_elig &
                       (~w_dbg_elig | r_last_dbg);
  assign w_grant_dbg = (r_state == S_IDLE) & i_rst_n & w_dbg_elig & ~w_grant_cpu;

  assign w_sel_we    = w_grant_dbg ? i_dbg_we    : i_cpu_we;
  assign w_sel_addr  = w_grant_dbg ? i_dbg_addr  : i_cpu_addr;
  assign w_sel_wdata = w_grant_dbg ? i_dbg_wdata : i_cpu_wdata;
  assign w_sel_size  = w_grant_dbg ? i_dbg_size  : i_cpu_size;

  // Alignment is judged once, on the request as granted.
  always_comb begin
    w_sel_fault = 1'b0;
    case (w_sel_size)
      2'b00:   w_sel_fault = (w_sel_addr[1:0] != 2'b00);
      2'b01:   w_sel_fault = w_sel_addr[0];
      2'b11:   w_sel_fault = 1'b0;
      default: w_sel_fault = 1'b1;
    endcase
  end

  assign w_do_write = (r_state == S_ACCESS) & r_we  & ~r_fault;
  assign w_do_read  = (r_state == S_ACCESS) & ~r_we & ~r_fault;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_grant_cpu | w_grant_dbg) w_next_state = S_ACCESS;
      S_ACCESS: w_next_state = S_RESP;
      S_RESP:   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Transaction latch, round-robin pointer and read-data capture
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_dbg <= 1'b1;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_size     <= 2'b00;
      r_port_dbg <= 1'b0;
      r_fault    <= 1'b0;
      r_rdata    <= '0;
    end else begin
      if (w_grant_cpu | w_grant_dbg) begin
        r_last_dbg <= w_grant_dbg;
        r_we       <= w_sel_we;
        r_addr     <= w_sel_addr;
        r_wdata    <= w_sel_wdata;
        r_size     <= w_sel_size;
        r_port_dbg <= w_grant_dbg;
        r_fault    <= w_sel_fault;
        r_rdata    <= '0;
      end
      if (w_do_read) begin
        r_rdata <= i_mem_r_data;
      end
    end
  end

  // Outputs: memory channels only in ACCESS, response only in RESP
  always_comb begin
    o_cpu_gnt          = w_grant_cpu;
    o_dbg_gnt          = w_grant_dbg;
    o_cpu_ack          = 1'b0;
    o_dbg_ack          = 1'b0;
    o_rdata            = '0;
    o_err              = 1'b0;
    o_mem_w_en         = w_do_write;
    o_mem_w_addr       = '0;
    o_mem_w_addressing = 2'b00;
    o_mem_w_data       = '0;
    o_mem_r_en         = w_do_read;
    o_mem_r_addr       = '0;
    o_mem_r_addressing = 2'b00;
    if (w_do_write) begin
      o_mem_w_addr       = r_addr;
      o_mem_w_addressing = r_size;
      o_mem_w_data       = r_wdata;
    end
    if (w_do_read) begin
      o_mem_r_addr       = r_addr;
      o_mem_r_addressing = r_size;
    end
    if (r_state == S_RESP) begin
      o_cpu_ack = ~r_port_dbg;
      o_dbg_ack = r_port_dbg;
      o_err     = r_fault;
      if (!r_fault && !r_we) begin
        o_rdata = r_rdata;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter
//   Directed vector table, hand-written corner sequences (reset mid-access,
//   alternating grants, byte-lane write) and a randomized run compared with
//   a transaction-level reference model. An external byte memory serves the
//   DUT's memory channels.
module tb_data_mem_arbiter;

  typedef struct packed {
    logic        cpu_req;
    logic        cpu_we;
    logic [5:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic [1:0]  cpu_size;
    logic        dbg_req;
    logic        dbg_we;
    logic [5:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic [1:0]  dbg_size;
    logic        lock;
  } in_t;

  typedef struct packed {
    logic        cpu_gnt;
    logic        dbg_gnt;
    logic        cpu_ack;
    logic        dbg_ack;
    logic        err;
    logic        w_en;
    logic        r_en;
    logic [5:0]  w_addr;
    logic [5:0]  r_addr;
    logic [1:0]  w_sz;
    logic [1:0]  r_sz;
    logic [31:0] w_data;
    logic [31:0] rdata;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t e;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
  logic [5:0]  cpu_addr, dbg_addr;
  logic [31:0] cpu_wdata, dbg_wdata;
  logic [1:0]  cpu_size, dbg_size;
  logic        cpu_gnt, dbg_gnt, cpu_ack, dbg_ack, err;
  logic [31:0] rdata;
  logic [5:0]  mem_r_addr, mem_w_addr;
  logic        mem_r_en, mem_w_en;
  logic [1:0]  mem_r_addressing, mem_w_addressing;
  logic [31:0] mem_w_data, mem_r_data;

  int n_tests = 0;
  int n_fail  = 0;

  // Environment memory (serves the DUT) and reference copy (used by model)
  logic [7:0] mem      [64];
  logic [7:0] init_pat [64];
  logic [7:0] ref_mem  [64];
  logic       do_init;

  data_mem_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr),
    .i_cpu_wdata(cpu_wdata), .i_cpu_size(cpu_size),
    .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr),
    .i_dbg_wdata(dbg_wdata), .i_dbg_size(dbg_size),
    .i_dbg_lock(dbg_lock),
    .o_cpu_gnt(cpu_gnt), .o_dbg_gnt(dbg_gnt),
    .o_cpu_ack(cpu_ack), .o_dbg_ack(dbg_ack),
    .o_rdata(rdata), .o_err(err),
    .o_mem_r_addr(mem_r_addr), .o_mem_w_addr(mem_w_addr),
    .o_mem_r_en(mem_r_en), .o_mem_w_en(mem_w_en),
    .o_mem_r_addressing(mem_r_addressing), .o_mem_w_addressing(mem_w_addressing),
    .o_mem_w_data(mem_w_data), .i_mem_r_data(mem_r_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int nbytes(logic [1:0] sz);
    return (sz == 2'b00) ? 4 : (sz == 2'b01) ? 2 : 1;
  endfunction

  // Little-endian byte memory: byte lane k of the bus maps to address a+k.
  always @(posedge clk) begin
    if (do_init) begin
      for (int k = 0; k < 64; k++) mem[k] <= init_pat[k];
    end else if (mem_w_en) begin
      for (int k = 0; k < nbytes(mem_w_addressing); k++)
        mem[6'(mem_w_addr + 6'(k))] <= mem_w_data[8*k +: 8];
    end
  end

  always_comb begin
    mem_r_data = '0;
    for (int k = 0; k < nbytes(mem_r_addressing); k++)
      mem_r_data[8*k +: 8] = mem[6'(mem_r_addr + 6'(k))];
  end

  function automatic out_t dut_out();
    out_t o;
    o.cpu_gnt = cpu_gnt;    o.dbg_gnt = dbg_gnt;
    o.cpu_ack = cpu_ack;    o.dbg_ack = dbg_ack;
    o.err     = err;        o.w_en    = mem_w_en;  o.r_en = mem_r_en;
    o.w_addr  = mem_w_addr; o.r_addr  = mem_r_addr;
    o.w_sz    = mem_w_addressing; o.r_sz = mem_r_addressing;
    o.w_data  = mem_w_data; o.rdata   = rdata;
    return o;
  endfunction

  task automatic check(input string name, input out_t exp);
    out_t got;
    got = dut_out();
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic drive(input in_t x);
    cpu_req = x.cpu_req; cpu_we = x.cpu_we; cpu_addr = x.cpu_addr;
    cpu_wdata = x.cpu_wdata; cpu_size = x.cpu_size;
    dbg_req = x.dbg_req; dbg_we = x.dbg_we; dbg_addr = x.dbg_addr;
    dbg_wdata = x.dbg_wdata; dbg_size = x.dbg_size;
    dbg_lock = x.lock;
  endtask

  // One cycle: inputs change just after the rising edge, outputs are
  // sampled on the falling edge.
  task automatic cyc(input in_t x);
    @(posedge clk);
    #1;
    drive(x);
    @(negedge clk);
  endtask

  function automatic in_t mk(bit cr, bit cw, logic [5:0] ca, logic [31:0] cd, logic [1:0] cs,
                             bit dr, bit dw, logic [5:0] da, logic [31:0] dd, logic [1:0] ds,
                             bit lk);
    in_t x;
    x.cpu_req = cr; x.cpu_we = cw; x.cpu_addr = ca; x.cpu_wdata = cd; x.cpu_size = cs;
    x.dbg_req = dr; x.dbg_we = dw; x.dbg_addr = da; x.dbg_wdata = dd; x.dbg_size = ds;
    x.lock = lk;
    return x;
  endfunction

  task automatic do_reset(input bit random_fill);
    in_t z;
    z = '0;
    rst_n = 1'b0;
    drive(z);
    for (int k = 0; k < 64; k++) begin
      init_pat[k] = random_fill ? 8'($urandom) : 8'h00;
      ref_mem[k]  = init_pat[k];
    end
    do_init = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_init = 1'b0;
    check("reset outputs", '0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t vt [18];

  // Reference model state (transaction level)
  int          busy;       // cycles of the current transaction still to come
  bit          last_dbg;
  bit          p_dbg, p_we, p_fault;
  logic [5:0]  p_addr;
  logic [31:0] p_wdata, p_cap;
  logic [1:0]  p_size;

  function automatic bit is_fault(logic [1:0] sz, logic [5:0] a);
    case (sz)
      2'b00:   return (a % 4) != 0;
      2'b01:   return (a % 2) != 0;
      2'b11:   return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] ref_read(logic [5:0] a, logic [1:0] sz);
    logic [31:0] v;
    v = 0;
    for (int k = 0; k < nbytes(sz); k++) v = v | (32'(ref_mem[(int'(a) + k) % 64]) << (8 * k));
    return v;
  endfunction

  initial begin
    in_t  idle, x;
    out_t e;
    bit   ce, de, gc, gd;
    idle = '0;
    do_init = 1'b0;

    // ---------------- directed vector table ----------------
    for (int k = 0; k < 18; k++) begin
      vt[k].i = idle;
      vt[k].e = '0;
    end
    vt[0].i  = mk(1, 1, 6'h08, 32'hDEADBEEF, 2'b00, 0, 0, 0, 0, 0, 0);
    vt[0].e.cpu_gnt = 1;
    vt[1].e.w_en = 1; vt[1].e.w_addr = 6'h08; vt[1].e.w_data = 32'hDEADBEEF;
    vt[2].e.cpu_ack = 1;
    vt[3].i  = mk(1, 0, 6'h08, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    vt[3].e.cpu_gnt = 1;
    vt[4].e.r_en = 1; vt[4].e.r_addr = 6'h08;
    vt[5].e.cpu_ack = 1; vt[5].e.rdata = 32'hDEADBEEF;
    vt[6].i  = mk(1, 0, 6'h06, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    vt[6].e.cpu_gnt = 1;
    vt[8].e.cpu_ack = 1; vt[8].e.err = 1;
    vt[9].i  = mk(1, 0, 6'h00, 0, 2'b00, 1, 0, 6'h08, 0, 2'b11, 1);
    vt[9].e.dbg_gnt = 1;
    vt[10].e.r_en = 1; vt[10].e.r_addr = 6'h08; vt[10].e.r_sz = 2'b11;
    vt[11].e.dbg_ack = 1; vt[11].e.rdata = 32'h000000EF;
    vt[12].i = vt[9].i;          // CPU would win here without the lock
    vt[12].e.dbg_gnt = 1;
    vt[13].e = vt[10].e;
    vt[14].e = vt[11].e;
    vt[15].i = mk(1, 0, 6'h08, 0, 2'b00, 1, 0, 6'h08, 0, 2'b11, 0);
    vt[15].e.cpu_gnt = 1;
    vt[16].e = vt[4].e;
    vt[17].e = vt[5].e;

    do_reset(1'b0);
    for (int k = 0; k < 18; k++) begin
      cyc(vt[k].i);
      check($sformatf("vec %0d", k), vt[k].e);
    end

    // ---------------- reset during a write access ----------------
    cyc(mk(1, 1, 6'h10, 32'h12345678, 2'b00, 0, 0, 0, 0, 0, 0));
    e = '0; e.cpu_gnt = 1;
    check("rst-mid gnt", e);
    cyc(idle);
    e = '0; e.w_en = 1; e.w_addr = 6'h10; e.w_data = 32'h12345678;
    check("rst-mid access", e);
    rst_n = 1'b0;
    #1;
    check("rst-mid wen drop", '0);
    @(posedge clk);
    #1;
    check("rst-mid held", '0);
    check_val("rst-mid mem untouched", {mem[19], mem[18], mem[17], mem[16]}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(idle);
      check($sformatf("rst-mid no ack %0d", k), '0);
    end

    // ---------------- alternating grants, both requesting ----------------
    for (int k = 0; k < 12; k++) begin
      cyc(mk(1, 0, 6'h00, 0, 2'b00, 1, 0, 6'h04, 0, 2'b00, 0));
      check_val($sformatf("alt gnt cyc %0d", k), {30'b0, cpu_gnt, dbg_gnt},
                (k % 3 != 0) ? 32'h0 : ((k / 3) % 2 == 0) ? 32'h2 : 32'h1);
    end

    // ---------------- debug byte write then word read ----------------
    cyc(mk(0, 0, 0, 0, 0, 1, 1, 6'h0D, 32'h000000AB, 2'b11, 0));
    e = '0; e.dbg_gnt = 1;
    check("byte wr gnt", e);
    cyc(idle);
    e = '0; e.w_en = 1; e.w_addr = 6'h0D; e.w_sz = 2'b11; e.w_data = 32'h000000AB;
    check("byte wr access", e);
    cyc(idle);
    e = '0; e.dbg_ack = 1;
    check("byte wr ack", e);
    cyc(mk(0, 0, 0, 0, 0, 1, 0, 6'h0C, 0, 2'b00, 0));
    e = '0; e.dbg_gnt = 1;
    check("word rd gnt", e);
    cyc(idle);
    e = '0; e.r_en = 1; e.r_addr = 6'h0C;
    check("word rd access", e);
    cyc(idle);
    check_val("word rd lane1", {24'b0, rdata[15:8]}, 32'hAB);
    e = '0; e.dbg_ack = 1; e.rdata = 32'h0000AB00;
    check("word rd ack", e);

    // ---------------- randomized run against the reference model ----------------
    do_reset(1'b1);
    busy = 0;
    last_dbg = 1;
    p_cap = 0;
    for (int c = 0; c < 600; c++) begin
      x.cpu_req   = ($urandom_range(0, 99) < 60);
      x.cpu_we    = 1'($urandom);
      x.cpu_addr  = 6'($urandom);
      x.cpu_wdata = $urandom;
      x.cpu_size  = 2'($urandom);
      x.dbg_req   = ($urandom_range(0, 99) < 50);
      x.dbg_we    = 1'($urandom);
      x.dbg_addr  = 6'($urandom);
      x.dbg_wdata = $urandom;
      x.dbg_size  = 2'($urandom);
      x.lock      = ($urandom_range(0, 99) < 25);
      cyc(x);

      e = '0;
      gc = 0;
      gd = 0;
      if (busy == 0) begin
        ce = x.cpu_req && !x.lock;
        de = x.dbg_req;
        if (ce && de) begin
          gc = last_dbg;
          gd = !last_dbg;
        end else begin
          gc = ce;
          gd = de;
        end
        e.cpu_gnt = gc;
        e.dbg_gnt = gd;
        if (gc || gd) begin
          p_dbg   = gd;
          p_we    = gd ? x.dbg_we    : x.cpu_we;
          p_addr  = gd ? x.dbg_addr  : x.cpu_addr;
          p_wdata = gd ? x.dbg_wdata : x.cpu_wdata;
          p_size  = gd ? x.dbg_size  : x.cpu_size;
          p_fault = is_fault(p_size, p_addr);
          p_cap   = 0;
        end
      end else if (busy == 2) begin
        if (!p_fault && p_we) begin
          e.w_en = 1; e.w_addr = p_addr; e.w_sz = p_size; e.w_data = p_wdata;
        end else if (!p_fault) begin
          e.r_en = 1; e.r_addr = p_addr; e.r_sz = p_size;
          p_cap = ref_read(p_addr, p_size);
        end
      end else begin
        e.cpu_ack = !p_dbg;
        e.dbg_ack = p_dbg;
        e.err     = p_fault;
        e.rdata   = (!p_fault && !p_we) ? p_cap : 32'h0;
      end

      check($sformatf("rand cyc %0d", c), e);

      if (busy == 2 && !p_fault && p_we)
        for (int k = 0; k < nbytes(p_size); k++)
          ref_mem[(int'(p_addr) + k) % 64] = p_wdata[8*k +: 8];
      if (gc || gd) begin
        busy = 2;
        last_dbg = gd;
      end else if (busy > 0) begin
        busy = busy - 1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
